// File: rtl/player_move_scheduler.sv
// Player movement scheduler.
// Turns a held joystick direction into single steps with keyboard-style
// auto-repeat. The first step happens immediately. A longer hold delay comes
// next, then a steady repeat rate. Coordinates saturate at the playfield
// edges, and a position-update pulse fires only when a coordinate actually
// changed.
module player_move_scheduler #(
    parameter int X_MAX       = 91,
    parameter int Y_MAX       = 59,
    parameter int X_START     = 44,
    parameter int Y_START     = 28,
    parameter int HOLD_CYCLES = 20_000_000,
    parameter int STEP_CYCLES = 2_500_000
) (
    input  logic       clock_100mhz,
    input  logic       reset,
    input  logic       game_active,
    input  logic [1:0] input_hor,
    input  logic [1:0] input_vert,
    output logic [6:0] player_x,
    output logic [5:0] player_y,
    output logic       pos_update,
    output logic       moving
);

    // The counter only ever holds 0 .. (longest interval - 1).
    localparam int CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    localparam logic [6:0] X_MAX_V   = 7'(X_MAX);
    localparam logic [5:0] Y_MAX_V   = 6'(Y_MAX);
    localparam logic [6:0] X_START_V = 7'(X_START);
    localparam logic [5:0] Y_START_V = 6'(Y_START);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dir_hist;     // direction that started the current hold

    logic [1:0]       hor_dec;
    logic [1:0]       vert_dec;
    logic [3:0]       dir;
    logic [6:0]       step_x;
    logic [5:0]       step_y;
    logic             step_changes;
    logic             interval_done;
    logic             at_spawn;

    // Decode the direction vector; pressing both ways on an axis cancels that axis.
    always_comb begin
        hor_dec  = (input_hor  == 2'b11) ? 2'b00 : input_hor;
        vert_dec = (input_vert == 2'b11) ? 2'b00 : input_vert;
        dir      = {hor_dec, vert_dec};
    end

    // Candidate x after one step: 01 moves left, 10 moves right, clamped at the edges.
    always_comb begin
        step_x = player_x;
        if (hor_dec == 2'b01 && player_x != 7'd0) begin
            step_x = player_x - 7'd1;
        end else if (hor_dec == 2'b10 && player_x < X_MAX_V) begin
            step_x = player_x + 7'd1;
        end
    end

    // Candidate y after one step: 01 moves up, 10 moves down, clamped at the edges.
    always_comb begin
        step_y = player_y;
        if (vert_dec == 2'b01 && player_y != 6'd0) begin
            step_y = player_y - 6'd1;
        end else if (vert_dec == 2'b10 && player_y < Y_MAX_V) begin
            step_y = player_y + 6'd1;
        end
    end

    // These flags decide when to step and whether the step changes the position.
    always_comb begin
        step_changes  = (step_x != player_x) || (step_y != player_y);
        interval_done = (state == DELAY)  ? (cnt == HOLD_LAST) :
                        (state == REPEAT) ? (cnt == STEP_LAST) : 1'b0;
        at_spawn      = (player_x == X_START_V) && (player_y == Y_START_V);
    end

    // Main FSM: position, hold/repeat timing and registered status outputs.
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dir_hist   <= 4'd0;
            player_x   <= X_START_V;
            player_y   <= Y_START_V;
            pos_update <= 1'b0;
            moving     <= 1'b0;
        end else begin
            pos_update <= 1'b0;
            if (!game_active) begin
                // Outside gameplay the player is pinned to spawn.
                state      <= IDLE;
                cnt        <= '0;
                dir_hist   <= 4'd0;
                moving     <= 1'b0;
                player_x   <= X_START_V;
                player_y   <= Y_START_V;
                pos_update <= !at_spawn;
            end else begin
                case (state)
                    IDLE: begin
                        if (dir != 4'd0) begin
                            player_x   <= step_x;
                            player_y   <= step_y;
                            pos_update <= step_changes;
                            cnt        <= '0;
                            dir_hist   <= dir;
                            state      <= DELAY;
                            moving     <= 1'b1;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (dir == 4'd0) begin
                            // Release abandons the hold without a step.
                            state    <= IDLE;
                            moving   <= 1'b0;
                            cnt      <= '0;
                            dir_hist <= 4'd0;
                        end else if (dir != dir_hist) begin
                            // A new direction behaves like a fresh press.
                            player_x   <= step_x;
                            player_y   <= step_y;
                            pos_update <= step_changes;
                            cnt        <= '0;
                            dir_hist   <= dir;
                            state      <= DELAY;
                        end else if (interval_done) begin
                            player_x   <= step_x;
                            player_y   <= step_y;
                            pos_update <= step_changes;
                            cnt        <= '0;
                            state      <= REPEAT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        moving   <= 1'b0;
                        cnt      <= '0;
                        dir_hist <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_move_scheduler.sv
// Bench for player_move_scheduler. It uses short hold and repeat times.
// The reference model thinks in terms of press age: a step on the press edge,
// a step HOLD edges later, then a step every STEP edges.
module tb_player_move_scheduler;

    localparam int HOLD    = 4;
    localparam int STEP    = 2;
    localparam int X_MAX   = 91;
    localparam int Y_MAX   = 59;
    localparam int X_START = 44;
    localparam int Y_START = 28;

    logic       clk;
    logic       reset;
    logic       game_active;
    logic [1:0] hor;
    logic [1:0] vert;
    logic [6:0] player_x;
    logic [5:0] player_y;
    logic       pos_update;
    logic       moving;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int mx, my;
    bit pressed;
    int pdh, pdv;
    int age;
    bit exp_upd;

    player_move_scheduler #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_START(X_START), .Y_START(Y_START),
        .HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP)
    ) dut (
        .clock_100mhz(clk),
        .reset(reset),
        .game_active(game_active),
        .input_hor(hor),
        .input_vert(vert),
        .player_x(player_x),
        .player_y(player_y),
        .pos_update(pos_update),
        .moving(moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int axis(input logic [1:0] code);
        return (code == 2'b01) ? -1 : ((code == 2'b10) ? 1 : 0);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".x"}, int'(player_x), mx);
        check({tag, ".y"}, int'(player_y), my);
        check({tag, ".upd"}, int'(pos_update), int'(exp_upd));
        check({tag, ".moving"}, int'(moving), int'(pressed));
        $display("t=%0t %s in: ga=%0b hor=%b vert=%b -> pos=(%0d,%0d) upd=%0b moving=%0b",
                 $time, tag, game_active, hor, vert, player_x, player_y, pos_update, moving);
    endtask

    task automatic model_reset();
        mx = X_START; my = Y_START; pressed = 0; pdh = 0; pdv = 0; age = 0; exp_upd = 0;
    endtask

    // One clock edge: advance the model with the inputs sampled at the edge, then compare.
    task automatic tick(input string tag);
        int dh, dv, ox, oy;
        bit do_step;
        @(posedge clk);
        ox = mx; oy = my;
        dh = axis(hor);
        dv = axis(vert);
        if (!game_active) begin
            mx = X_START; my = Y_START; pressed = 0;
        end else if (dh == 0 && dv == 0) begin
            pressed = 0;
        end else begin
            if (!pressed || dh != pdh || dv != pdv) begin
                pressed = 1; pdh = dh; pdv = dv; age = 0; do_step = 1;
            end else begin
                age++;
                do_step = (age == HOLD) || (age > HOLD && ((age - HOLD) % STEP) == 0);
            end
            if (do_step) begin
                mx = clamp(mx + dh, X_MAX);
                my = clamp(my + dv, Y_MAX);
            end
        end
        exp_upd = (mx != ox) || (my != oy);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; game_active = 1'b0; hor = 2'b00; vert = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Hold right: step at once, then after the hold delay, then at the repeat rate.
        @(negedge clk);
        reset = 1'b0; game_active = 1'b1; hor = 2'b10;
        tick("right0");
        check("right0.x_const", int'(player_x), 45);
        for (int i = 1; i < 10; i++) tick("right_hold");

        // Reverse direction while repeating: an immediate left step and a new hold.
        hor = 2'b01;
        for (int i = 0; i < 8; i++) tick("reverse");

        // Release, then return to spawn for the diagonal step.
        hor = 2'b00;
        tick("release");
        game_active = 1'b0;
        tick("to_spawn");
        game_active = 1'b1; hor = 2'b01; vert = 2'b10;
        tick("diag");
        check("diag.x_const", int'(player_x), 43);
        check("diag.y_const", int'(player_y), 29);
        hor = 2'b00; vert = 2'b00;
        tick("release2");

        // Both horizontal buttons together cancel: no step and no motion.
        hor = 2'b11;
        for (int i = 0; i < 5; i++) tick("hor11");

        // Run into the right wall and keep pushing.
        hor = 2'b10;
        for (int i = 0; i < 200 && mx < X_MAX; i++) tick("to_wall");
        for (int i = 0; i < 8; i++) tick("wall_push");
        check("wall.x_const", int'(player_x), X_MAX);

        // game_active drop from (50,10) returns to spawn with one pulse.
        game_active = 1'b0; hor = 2'b00;
        tick("spawn_again");
        game_active = 1'b1; hor = 2'b10;
        for (int i = 0; i < 100 && mx < 50; i++) tick("go_x50");
        hor = 2'b00; vert = 2'b01;
        for (int i = 0; i < 100 && my > 10; i++) tick("go_y10");
        vert = 2'b00;
        tick("stop_50_10");
        game_active = 1'b0;
        tick("drop");
        check("drop.x_const", int'(player_x), X_START);
        check("drop.upd_const", int'(pos_update), 1);
        tick("drop_hold");

        // Asynchronous reset in the middle of a repeat sequence.
        game_active = 1'b1; hor = 2'b10;
        for (int i = 0; i < 8; i++) tick("pre_reset");
        reset = 1'b1;
        #2;
        model_reset();
        check_all("async_reset");
        reset = 1'b0;
        tick("after_reset");
        check("after_reset.x_const", int'(player_x), X_START + 1);

        // Random inputs against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                hor  = 2'($urandom_range(0, 3));
                vert = 2'($urandom_range(0, 3));
            end
            game_active = ($urandom_range(0, 49) != 0);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
